// File: rtl/ecc_secded_pipe.sv
// ecc_secded_pipe: 2-stage pipelined SEC-DED Hamming generator/checker with a
// valid/ready stream interface.
// Optional build macro ECC_ERR_CNT_EN adds saturating single/multi-bit error
// counters (sbe_cnt, mbe_cnt, clr_cnt ports).
module ecc_secded_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned CHK_W = ((DATA_W <= 4)  ? 3 :
                                   (DATA_W <= 11) ? 4 :
                                   (DATA_W <= 26) ? 5 :
                                   (DATA_W <= 57) ? 6 : 7) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              gen,
  input  logic              correct_n,
  input  logic [DATA_W-1:0] datain,
  input  logic [CHK_W-1:0]  chkin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic [CHK_W-1:0]  chkout,
  output logic              err_detect,
  output logic              err_multpl
`ifdef ECC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  sbe_cnt,
  output logic [CNT_W-1:0]  mbe_cnt,
  input  logic              clr_cnt
`endif
);

  // Number of Hamming bits; CHK_W adds the overall parity bit on top.
  localparam int unsigned R = CHK_W - 1;

  // Codeword position of data bit j: the j-th non-power-of-two position >= 3.
  function automatic int unsigned data_pos(input int unsigned j);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned p = 3; p < 128; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == j) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Stage 1 registers (raw word and mode)
  logic              s1_valid_q;
  logic              s1_gen_q;
  logic              s1_cn_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [CHK_W-1:0]  s1_chk_q;

  // Stage 2 registers (results driven to the outputs)
  logic              out_valid_q;
  logic [DATA_W-1:0] dataout_q;
  logic [CHK_W-1:0]  chkout_q;
  logic              det_q;
  logic              mul_q;

  // Results computed from stage 1
  logic [R-1:0]      hcalc;
  logic [DATA_W-1:0] flip;
  logic [DATA_W-1:0] dataout_d;
  logic [CHK_W-1:0]  chkout_d;
  logic              det_d;
  logic              mul_d;
  logic [R-1:0]      syn;
  logic              par;
  logic              dpar;

  logic stall;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Hamming bits over stage-1 data, and the data bit addressed by the syndrome
  always_comb begin : p_hamming
    logic [R-1:0] pos_v;
    hcalc = '0;
    flip  = '0;
    pos_v = '0;
    syn   = hcalc ^ s1_chk_q[R-1:0];
    for (int unsigned j = 0; j < DATA_W; j++) begin
      pos_v = R'(data_pos(j));
      for (int unsigned i = 0; i < R; i++) begin
        if (pos_v[i]) hcalc[i] = hcalc[i] ^ s1_data_q[j];
      end
    end
    syn = hcalc ^ s1_chk_q[R-1:0];
    for (int unsigned j = 0; j < DATA_W; j++) begin
      if (syn == R'(data_pos(j))) flip[j] = 1'b1;
    end
  end

  // Mode-dependent results: check bits / syndrome, classification, correction
  always_comb begin
    dpar      = ^s1_data_q;
    par       = dpar ^ (^s1_chk_q);
    dataout_d = s1_data_q;
    chkout_d  = {par, syn};
    det_d     = 1'b0;
    mul_d     = 1'b0;
    if (s1_gen_q) begin
      chkout_d = {dpar ^ (^hcalc), hcalc};
    end else begin
      det_d = par | (syn != '0);
      mul_d = ~par & (syn != '0);
      if (par && !s1_cn_q) dataout_d = s1_data_q ^ flip;
    end
  end

  // Both stages advance together unless the output is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_gen_q    <= 1'b0;
      s1_cn_q     <= 1'b0;
      s1_data_q   <= '0;
      s1_chk_q    <= '0;
      out_valid_q <= 1'b0;
      dataout_q   <= '0;
      chkout_q    <= '0;
      det_q       <= 1'b0;
      mul_q       <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_gen_q  <= gen;
        s1_cn_q   <= correct_n;
        s1_data_q <= datain;
        s1_chk_q  <= chkin;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        dataout_q <= dataout_d;
        chkout_q  <= chkout_d;
        det_q     <= det_d;
        mul_q     <= mul_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign dataout    = dataout_q;
  assign chkout     = chkout_q;
  assign err_detect = det_q;
  assign err_multpl = mul_q;

`ifdef ECC_ERR_CNT_EN
  logic [CNT_W-1:0] sbe_q;
  logic [CNT_W-1:0] mbe_q;
  logic             out_fire;

  assign out_fire = out_valid_q & out_ready;

  // Saturating error counters; err_detect is already 0 for generate-mode words
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      sbe_q <= '0;
      mbe_q <= '0;
    end else if (out_fire) begin
      if (det_q && !mul_q && (sbe_q != '1)) sbe_q <= sbe_q + CNT_W'(1);
      if (mul_q && (mbe_q != '1)) mbe_q <= mbe_q + CNT_W'(1);
    end
  end

  assign sbe_cnt = sbe_q;
  assign mbe_cnt = mbe_q;
`else
  // CNT_W only sizes the counters, which are absent in this build.
  if (CNT_W == 0) begin : g_no_counters
  end
`endif

endmodule
